// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the pipeline and the multiply/divide unit
interface muldiv_if #(parameter int WIDTH = 32) ();
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a, b;
  logic mthi, mtlo, busy, done;
  logic [WIDTH-1:0] hi, lo;
  modport master(output start, op, a, b, mthi, mtlo, input busy, done, hi, lo);
  modport slave(input start, op, a, b, mthi, mtlo, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide owning the HI/LO pair
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER = 32
) (
  input logic clk,
  input logic rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(ITER + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r, bz, sgn;
  logic [WIDTH-1:0] m, r, q, a_mag, b_mag;
  logic [WIDTH:0] sum, sh, diff;
  logic [2*WIDTH-1:0] prod;
  // r/q double as the product's upper/lower halves when multiplying and as remainder/quotient when dividing
  always_comb begin
    sgn = ~bus.op[0];
    a_mag = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    sum = {1'b0, r} + (q[0] ? {1'b0, m} : '0);
    sh = {r, q[WIDTH-1]};
    diff = sh - {1'b0, m};
    prod = neg_q ? -{r, q} : {r, q};
    state_d = state == IDLE ? (bus.start ? RUN : IDLE) :
              state == RUN ? (cnt == CW'(ITER - 1) ? FIX : RUN) : IDLE;
    bus.busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.done <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      state <= state_d;
      bus.done <= state == FIX;
      if (state == IDLE && bus.start) begin
        is_div <= bus.op[1];
        neg_q <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_r <= sgn && bus.a[WIDTH-1];
        bz <= bus.b == '0;
        r <= '0;
        cnt <= '0;
        m <= bus.op[1] ? b_mag : a_mag;
        q <= bus.op[1] ? a_mag : b_mag;
      end else if (state == IDLE) begin
        if (bus.mthi) bus.hi <= bus.a;
        if (bus.mtlo) bus.lo <= bus.a;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        if (is_div) begin
          r <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
          q <= {q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          r <= sum[WIDTH:1];
          q <= {sum[0], q[WIDTH-1:1]};
        end
      end else begin
        // divide by zero leaves |a| as remainder, so the dividend sign fix restores a itself
        bus.hi <= is_div ? (neg_r ? -r : r) : prod[2*WIDTH-1:WIDTH];
        bus.lo <= is_div ? (bz ? '1 : neg_q ? -q : q) : prod[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors with a result scoreboard plus hand-written corner sequences
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b1;
  int tests = 0, failed = 0;
  logic [63:0] sb[$];
  typedef struct {
    logic [1:0] op;
    logic [31:0] a, b, eh, el;
  } vec_t;
  vec_t tbl[13];
  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit mt);
    int k = 0;
    logic [31:0] ph;
    while (bus.busy && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk("idle_timeout", 32'd1, 32'd0);
    ph = bus.hi;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.mthi = mt;
    sb.push_back({eh, el});
    tick();
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.a = 32'hA5A5A5A5;
    bus.b = 32'h5A5A5A5A;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    chk("done_low_after_start", {31'd0, bus.done}, 32'd0);
    if (mt) chk("start_beats_mthi", bus.hi, ph);
  endtask
  // mode 1: stray starts in RUN and FIX; mode 2: mthi/mtlo while busy
  task automatic finish(input string name, input int mode);
    int n = 0;
    logic [31:0] ph = bus.hi, pl = bus.lo;
    logic [63:0] e;
    while (n < 40) begin
      tick();
      n++;
      if (bus.done) break;
      if (n == 10) chk({name, "_hi_hold"}, bus.hi, ph);
      if (n == 4 && mode == 2) begin
        chk({name, "_busy_mthi"}, bus.hi, ph);
        chk({name, "_busy_mtlo"}, bus.lo, pl);
      end
      bus.start = mode == 1 && (n == 5 || n == 32);
      bus.op = 2'b01;
      bus.a = 32'd3;
      bus.b = 32'd3;
      bus.mthi = mode == 2 && n == 3;
      bus.mtlo = mode == 2 && n == 3;
    end
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk({name, "_latency"}, n, 33);
    chk({name, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
    if (sb.size() == 0) chk({name, "_sb_empty"}, 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk({name, "_hi"}, bus.hi, e[63:32]);
      chk({name, "_lo"}, bus.lo, e[31:0]);
    end
  endtask
  initial begin
    int nd;
    tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1] = '{2'b00, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6};
    tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF};
    tbl[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
    tbl[5] = '{2'b11, 32'd50, 32'd7, 32'd1, 32'd7};
    tbl[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    tbl[7] = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    tbl[8] = '{2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF};
    tbl[9] = '{2'b01, 32'h12345678, 32'h10, 32'd1, 32'h23456780};
    tbl[10] = '{2'b11, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF};
    tbl[11] = '{2'b00, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0};
    tbl[12] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    bus.a = 32'h12345678;
    bus.mthi = 1'b1;
    tick();
    bus.mthi = 1'b0;
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_lo", bus.lo, 32'd0);
    bus.a = 32'h9ABCDEF0;
    bus.mtlo = 1'b1;
    tick();
    bus.mtlo = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h9ABCDEF0);
    chk("mtlo_hi", bus.hi, 32'h12345678);
    bus.a = 32'h55;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mtboth_hi", bus.hi, 32'h55);
    chk("mtboth_lo", bus.lo, 32'h55);
    launch(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);
    finish("mt_busy", 2);
    for (int i = 0; i < 13; i++) begin
      launch(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, 1'b0);
      finish($sformatf("vec%0d", i), i == 0 ? 1 : 0);
    end
    launch(2'b11, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    nd = 0;
    repeat (40) begin
      tick();
      if (bus.done) nd++;
    end
    chk("midrst_no_done", nd, 0);
    launch(2'b11, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0);
    finish("fresh_divu", 1);
    launch(2'b00, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    finish("back_to_back", 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle iterative multiply/divide unit beside the single-cycle ALU in the EX stage.
- Owns the HI/LO register pair and supplies HI/LO to the pipeline for MFHI and MFLO.
- Drives busy so the hazard logic stalls any MFHI, MFLO or new mult/div until the result is written.
- Issue side is start/op; result side is busy/done/hi/lo.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iterations per operation. Must equal WIDTH; one bit per cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch the operation selected by op; sampled on a clk edge.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  input  WIDTH  operand rs (multiplicand or dividend).
- b  input  WIDTH  operand rt (multiplier or divisor).
- mthi  input  1  write a into HI (MTHI).
- mtlo  input  1  write a into LO (MTLO).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO receive a new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: all of the following return to their reset values on the first rst edge, including mid-operation.
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0.
  - Any in-flight operation is discarded.
- States and transitions:
  - IDLE to RUN when start=1 at an edge.
  - RUN to FIX after ITER iterations.
  - FIX to IDLE after one edge.
- Launch edge (E0), IDLE with start=1:
  - Latch op.
  - Latch operand magnitudes |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Record the result signs.
  - Clear the iteration counter.
  - busy=1 from E0.
- RUN, edges E1..E32, one iteration per edge:
  - Multiply: shift-add. Each edge examines one multiplier bit and accumulates into a 64-bit product.
  - Divide: restoring. Each edge shifts one dividend bit into the remainder, trial-subtracts the divisor, and shifts the quotient bit into the quotient.
- FIX, edge E33:
  - Apply the sign corrections.
  - Write hi/lo.
  - done=1 for the single cycle after E33.
  - busy=0 after E33.
  - Total latency: hi/lo hold the new result 33 cycles after the start edge.
- Result mapping:
  - Multiply: {hi,lo} = 64-bit product. For signed ops, negate when the operand signs differ.
  - Divide: lo = quotient, hi = remainder.
  - Signed quotient is negated when the signs differ. Signed remainder takes the sign of the dividend (truncating division).
- Divide by zero, all ops:
  - The unit still takes the full 33 cycles.
  - hi = original a, lo = 32'hFFFFFFFF. No exception is raised.
- Signed overflow, DIV of 32'h80000000 by 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- hi/lo change only on a FIX edge or an accepted mthi/mtlo. They hold during RUN, so they keep the prior values while busy.
- start while busy=1: ignored. The hazard unit must not issue it.
- mthi/mtlo:
  - Accepted only in IDLE with start=0, written on that edge.
  - If mthi and mtlo are both 1, both registers get a.
  - Ignored while busy or in the same cycle as start; start wins.
- done and start in the same cycle (FIX state): start is ignored, because the state is not yet IDLE. The next start is accepted from the cycle where busy=0.
- Operand inputs a and b are don't-care after E0.

Test Plan:
- Reset, then MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> busy=1 for 33 cycles, done pulses once; hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT a=-7 (32'hFFFFFFF9), b=6 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFD6 (-42); DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIVU a=100, b=0 -> after 33 cycles hi=100, lo=32'hFFFFFFFF; DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- mthi with a=32'h12345678, then mtlo with a=32'h9ABCDEF0 in IDLE -> hi/lo update on the same edge. The same writes during busy leave hi/lo unchanged.
- Start DIVU 50/7, assert rst at cycle 10 -> busy=0, hi=lo=0 next cycle, no done pulse; a fresh DIVU 50/7 then gives lo=7, hi=1.
- Start asserted during RUN and during the FIX cycle -> ignored, result and latency unchanged; a start on the cycle after done begins a new 33-cycle operation.
